// File: rtl/i2c_types_pkg.sv
// rtl/i2c_types_pkg.sv - shared I2C types: transfer direction and target FSM states
`timescale 1ns/1ps
package i2c_types_pkg;

    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic {
        I2C_OP_WRITE = 1'b0,
        I2C_OP_READ  = I2C_RW_READ
    } i2c_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } i2c_slv_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
`timescale 1ns/1ps
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Flops reset to the idle-bus level so leaving reset never fakes an edge
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    assign scl_s     = scl_sr[SYNC_STAGES-1];
    assign sda_s     = sda_sr[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target: fixed-address match, write sink and read source
`timescale 1ns/1ps
module i2c_slave_responder
    import i2c_types_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                        SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      rx_valid_o,
    output logic                      tx_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
    output logic                      op_o,
    output logic                      busy_o,
    output logic                      stop_o
);

    localparam int DW = I2C_DATA_WIDTH;

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_slv_state_t state, state_n;
    i2c_op_t        op, op_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [DW-1:0]  shreg, shreg_n, rx_data, rx_data_n, shift_in;
    logic           sda_drv, sda_drv_n, rx_pend, rx_pend_n, rx_valid, rx_valid_n;
    logic           tx_req, tx_req_n, busy, busy_n, stop_p, stop_n;

    assign shift_in = {shreg[DW-2:0], sda_s};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            op       <= I2C_OP_WRITE;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            sda_drv  <= 1'b1;
            rx_pend  <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            stop_p   <= 1'b0;
        end else begin
            state    <= state_n;
            op       <= op_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            rx_data  <= rx_data_n;
            sda_drv  <= sda_drv_n;
            rx_pend  <= rx_pend_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
            busy     <= busy_n;
            stop_p   <= stop_n;
        end
    end

    // In the ACK states sda_drv doubles as the phase flag: 1 = ACK not yet driven
    always_comb begin
        state_n    = state;
        op_n       = op;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rx_data_n  = rx_data;
        sda_drv_n  = sda_drv;
        busy_n     = busy;
        rx_pend_n  = 1'b0;
        rx_valid_n = rx_pend;
        tx_req_n   = 1'b0;
        stop_n     = 1'b0;
        if (stop_det) begin
            state_n   = S_IDLE;
            sda_drv_n = 1'b1;
            busy_n    = 1'b0;
            stop_n    = 1'b1;
            bit_cnt_n = '0;
        end else if (start_det) begin
            state_n   = S_ADDR;
            sda_drv_n = 1'b1;
            busy_n    = 1'b0;
            bit_cnt_n = '0;
            shreg_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = shift_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shreg[I2C_ADDR_WIDTH-1:0] == SLAVE_ADDR) begin
                                state_n = S_ADDR_ACK;
                                op_n    = i2c_op_t'(sda_s);
                                busy_n  = 1'b1;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_rise && !sda_drv && op == I2C_OP_READ)
                        tx_req_n = 1'b1;
                    if (scl_fall) begin
                        if (sda_drv) begin
                            sda_drv_n = 1'b0;
                        end else if (op == I2C_OP_READ) begin
                            sda_drv_n = tx_data_i[DW-1];
                            shreg_n   = {tx_data_i[DW-2:0], 1'b0};
                            state_n   = S_RD_DATA;
                        end else begin
                            sda_drv_n = 1'b1;
                            state_n   = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = shift_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n = shift_in;
                            rx_pend_n = 1'b1;
                            state_n   = S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (sda_drv) begin
                            sda_drv_n = 1'b0;
                        end else begin
                            sda_drv_n = 1'b1;
                            state_n   = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    // bit_cnt counts rises; the fall after it wraps to 0 ends the byte
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_drv_n = 1'b1;
                            state_n   = S_RD_ACK;
                        end else begin
                            sda_drv_n = shreg[DW-1];
                            shreg_n   = {shreg[DW-2:0], 1'b0};
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            busy_n  = 1'b0;
                            state_n = S_IGNORE;
                        end else begin
                            tx_req_n = 1'b1;
                        end
                    end else if (scl_fall) begin
                        sda_drv_n = tx_data_i[DW-1];
                        shreg_n   = {tx_data_i[DW-2:0], 1'b0};
                        bit_cnt_n = '0;
                        state_n   = S_RD_DATA;
                    end
                end
                S_IGNORE: sda_drv_n = 1'b1;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    assign sda_o      = sda_drv;
    assign rx_data_o  = rx_data;
    assign rx_valid_o = rx_valid;
    assign tx_req_o   = tx_req;
    assign op_o       = op;
    assign busy_o     = busy;
    assign stop_o     = stop_p;

endmodule
